// File: rtl/kpn_queue_pkg.sv
// Shared types and defaults for the KPN channel queues (write-side and precharged read-side).
// Both queue endpoints import this so token and pointer widths stay consistent.
package kpn_queue_pkg;

   localparam int DEF_BITS_NUMBER   = 16;
   localparam int DEF_FIFO_ELEMENTS = 5;
   localparam int QUEUE_DEPTH       = 2**DEF_FIFO_ELEMENTS;

   typedef logic [DEF_BITS_NUMBER-1:0]   token_t;
   typedef logic [DEF_FIFO_ELEMENTS-1:0] ptr_t;

   // Occupancy needs one more bit than a pointer to represent a full queue.
   function automatic logic [DEF_FIFO_ELEMENTS:0] depth_count();
      return (DEF_FIFO_ELEMENTS+1)'(QUEUE_DEPTH);
   endfunction

endpackage

// File: rtl/queue_ptr_unit.sv
// Wrapping ring pointer with increment enable; wraps naturally at 2**W.
module queue_ptr_unit #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ptr <= '0;
      else if (inc) ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/queue_write_module.sv
// Write-side KPN channel endpoint: circular register buffer with a registered rd/valid read port.
// Optional macro QUEUE_OVERFLOW_COUNT_EN adds a saturating dropped-write counter output.
module queue_write_module
   import kpn_queue_pkg::*;
#(
   parameter int BITS_NUMBER   = DEF_BITS_NUMBER,
   parameter int FIFO_ELEMENTS = DEF_FIFO_ELEMENTS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr,
   input  logic [BITS_NUMBER-1:0]   input_1,
   input  logic                     rd,
   output logic [BITS_NUMBER-1:0]   output_1,
   output logic                     valid,
   output logic                     full,
   output logic                     empty,
   output logic [FIFO_ELEMENTS:0]   count
`ifdef QUEUE_OVERFLOW_COUNT_EN
   ,output logic [15:0]             overflow_count
`endif
);

   localparam int                   DEPTH     = 2**FIFO_ELEMENTS;
   localparam logic [FIFO_ELEMENTS:0] DEPTH_CNT = (FIFO_ELEMENTS+1)'(DEPTH);

   logic [BITS_NUMBER-1:0]   mem [DEPTH];
   logic [FIFO_ELEMENTS-1:0] w_ptr;
   logic [FIFO_ELEMENTS-1:0] r_ptr;
   logic                     wr_ok;
   logic                     rd_ok;

   // Flags come from the registered count, so full/empty never depend on pointer equality.
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);

   // A full queue still takes a write when the same edge frees a slot.
   assign rd_ok = rd & ~empty;
   assign wr_ok = wr & (~full | rd_ok);

   queue_ptr_unit #(.W(FIFO_ELEMENTS)) u_w_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_ok),
      .ptr   (w_ptr)
   );

   queue_ptr_unit #(.W(FIFO_ELEMENTS)) u_r_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_ok),
      .ptr   (r_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_ok) mem[w_ptr] <= input_1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output_1 <= '0;
         valid    <= 1'b0;
      end else if (rd_ok) begin
         output_1 <= mem[r_ptr];
         valid    <= 1'b1;
      end else begin
         output_1 <= '0;
         valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         unique case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef QUEUE_OVERFLOW_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow_count <= '0;
      else if (wr && !wr_ok && overflow_count != 16'hFFFF)
         overflow_count <= overflow_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_queue_write_module.sv
// Self-checking bench for queue_write_module against a queue-based reference model.
module tb_queue_write_module;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [15:0] input_1 = '0;
   logic [15:0] output_1;
   logic        valid, full, empty;
   logic [5:0]  count;
`ifdef QUEUE_OVERFLOW_COUNT_EN
   logic [15:0] overflow_count;
`endif

   int checks = 0;
   int failures = 0;

   logic [15:0] q[$];
   logic [15:0] exp_out;
   logic        exp_valid;
   int          exp_ovf;

   queue_write_module dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr),
      .input_1  (input_1),
      .rd       (rd),
      .output_1 (output_1),
      .valid    (valid),
      .full     (full),
      .empty    (empty),
      .count    (count)
`ifdef QUEUE_OVERFLOW_COUNT_EN
      ,.overflow_count (overflow_count)
`endif
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the model advances from the queue rules, outputs sampled 1ns after the edge.
   task automatic drive_cycle(input logic w, input logic r, input logic [15:0] d);
      bit m_full, m_empty, w_ok, r_ok;
      @(negedge clk);
      wr = w; rd = r; input_1 = d;
      @(posedge clk);
      m_full  = (q.size() == 32);
      m_empty = (q.size() == 0);
      r_ok = r && !m_empty;
      w_ok = w && (!m_full || r_ok);
      if (r_ok) begin exp_out = q.pop_front(); exp_valid = 1'b1; end
      else begin exp_out = 16'h0; exp_valid = 1'b0; end
      if (w_ok) q.push_back(d);
      if (w && !w_ok && exp_ovf < 65535) exp_ovf++;
      #1;
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete(); exp_out = 16'h0; exp_valid = 1'b0; exp_ovf = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 || output_1 !== 16'h0) begin
         failures++;
         $display("FAIL reset_async count=%0d empty=%b full=%b valid=%b out=%h want 0/1/0/0/0000",
                  count, empty, full, valid, output_1);
      end
      q.delete(); exp_out = 16'h0; exp_valid = 1'b0; exp_ovf = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 1'b0, 16'h0);
         checks++;
         if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || valid !== 1'b0 || output_1 !== 16'h0) begin
            failures++;
            $display("FAIL reset_idle%0d count=%0d empty=%b full=%b valid=%b out=%h want 0/1/0/0/0000",
                     i, count, empty, full, valid, output_1);
         end
      end
`ifdef QUEUE_OVERFLOW_COUNT_EN
      checks++;
      if (overflow_count !== 16'h0) begin
         failures++;
         $display("FAIL reset_ovf got=%0d want=0", overflow_count);
      end
`endif
   endtask

   task automatic test_basic_order();
      apply_reset();
      for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 1'b0, 16'(i));
      checks++;
      if (count !== 6'd4 || empty !== 1'b0) begin
         failures++;
         $display("FAIL basic_count got=%0d empty=%b want=4/0", count, empty);
      end
      for (int i = 1; i <= 4; i++) begin
         drive_cycle(1'b0, 1'b1, 16'h0);
         checks++;
         if (output_1 !== 16'(i) || valid !== 1'b1 || output_1 !== exp_out) begin
            failures++;
            $display("FAIL basic_rd%0d out=%h valid=%b want=%h/1", i, output_1, valid, 16'(i));
         end
      end
      checks++;
      if (count !== 6'd0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL basic_drain count=%0d empty=%b want=0/1", count, empty);
      end
   endtask

   task automatic test_fill_overflow();
      apply_reset();
      for (int i = 0; i < 33; i++) begin
         drive_cycle(1'b1, 1'b0, 16'h0100 + 16'(i));
         if (i == 30) begin
            checks++;
            if (full !== 1'b0 || count !== 6'd31) begin
               failures++;
               $display("FAIL fill_31 full=%b count=%0d want=0/31", full, count);
            end
         end
         if (i >= 31) begin
            checks++;
            if (full !== 1'b1 || count !== 6'd32 || count !== 6'(q.size())) begin
               failures++;
               $display("FAIL fill_full%0d full=%b count=%0d want=1/32", i + 1, full, count);
            end
         end
      end
`ifdef QUEUE_OVERFLOW_COUNT_EN
      checks++;
      if (overflow_count !== 16'd1 || overflow_count !== 16'(exp_ovf)) begin
         failures++;
         $display("FAIL fill_ovf got=%0d want=1", overflow_count);
      end
`endif
      for (int i = 0; i < 32; i++) begin
         drive_cycle(1'b0, 1'b1, 16'h0);
         checks++;
         if (output_1 !== 16'h0100 + 16'(i) || valid !== 1'b1) begin
            failures++;
            $display("FAIL fill_rd%0d out=%h valid=%b want=%h/1", i, output_1, valid, 16'h0100 + 16'(i));
         end
      end
      checks++;
      if (empty !== 1'b1 || count !== 6'd0) begin
         failures++;
         $display("FAIL fill_drain empty=%b count=%0d want=1/0", empty, count);
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] last;
      apply_reset();
      drive_cycle(1'b1, 1'b1, 16'hAAAA);
      checks++;
      if (valid !== 1'b0 || output_1 !== 16'h0 || count !== 6'd1) begin
         failures++;
         $display("FAIL sim_empty valid=%b out=%h count=%0d want=0/0000/1", valid, output_1, count);
      end
      drive_cycle(1'b0, 1'b1, 16'h0);
      checks++;
      if (output_1 !== 16'hAAAA || valid !== 1'b1) begin
         failures++;
         $display("FAIL sim_empty_rd out=%h valid=%b want=aaaa/1", output_1, valid);
      end
      for (int i = 0; i < 32; i++) drive_cycle(1'b1, 1'b0, 16'h0200 + 16'(i));
      drive_cycle(1'b1, 1'b1, 16'hBBBB);
      checks++;
      if (count !== 6'd32 || full !== 1'b1 || output_1 !== 16'h0200 || valid !== 1'b1) begin
         failures++;
         $display("FAIL sim_full count=%0d full=%b out=%h valid=%b want=32/1/0200/1",
                  count, full, output_1, valid);
      end
      last = 16'h0;
      for (int i = 0; i < 32; i++) begin
         drive_cycle(1'b0, 1'b1, 16'h0);
         checks++;
         if (output_1 !== exp_out || valid !== 1'b1) begin
            failures++;
            $display("FAIL sim_drain%0d out=%h valid=%b want=%h/1", i, output_1, valid, exp_out);
         end
         last = output_1;
      end
      checks++;
      if (last !== 16'hBBBB || empty !== 1'b1) begin
         failures++;
         $display("FAIL sim_last got=%h empty=%b want=bbbb/1", last, empty);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] data_ctr, next_rd;
      int bad = 0;
      apply_reset();
      data_ctr = 16'h0;
      next_rd  = 16'h0;
      for (int i = 0; i < 100; i++) begin
         logic w, r;
         w = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 1) != 0);
         drive_cycle(w, r, data_ctr);
         if (w && q.size() > 0 && q[q.size()-1] == data_ctr) data_ctr++;
         checks++;
         if (count !== 6'(q.size()) || valid !== exp_valid || output_1 !== exp_out ||
             full !== (q.size() == 32) || empty !== (q.size() == 0)) begin
            failures++; bad++;
            if (bad < 10)
               $display("FAIL wrap_cyc%0d count=%0d valid=%b out=%h want=%0d/%b/%h",
                        i, count, valid, output_1, q.size(), exp_valid, exp_out);
         end
         if (valid === 1'b1) begin
            checks++;
            if (output_1 !== next_rd) begin
               failures++;
               $display("FAIL wrap_seq%0d got=%h want=%h", i, output_1, next_rd);
            end
            next_rd = output_1 + 16'h1;
         end
      end
      checks++;
      if (data_ctr < 16'd33) begin
         failures++;
         $display("FAIL wrap_cover writes=%0d want>=33", data_ctr);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 16'h0900 + 16'(i));
      checks++;
      if (count !== 6'd10) begin
         failures++;
         $display("FAIL mid_pre count=%0d want=10", count);
      end
      drive_cycle(1'b0, 1'b1, 16'h0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 6'd0 || empty !== 1'b1 || valid !== 1'b0 || output_1 !== 16'h0) begin
         failures++;
         $display("FAIL mid_reset count=%0d empty=%b valid=%b out=%h want=0/1/0/0000",
                  count, empty, valid, output_1);
      end
      q.delete(); exp_out = 16'h0; exp_valid = 1'b0; exp_ovf = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b0, 1'b1, 16'h0);
      checks++;
      if (valid !== 1'b0 || output_1 !== 16'h0 || count !== 6'd0) begin
         failures++;
         $display("FAIL mid_empty_rd valid=%b out=%h count=%0d want=0/0000/0", valid, output_1, count);
      end
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 16'h0C00 + 16'(i));
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b1, 16'h0);
         checks++;
         if (output_1 !== 16'h0C00 + 16'(i) || valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_rd%0d out=%h valid=%b want=%h/1", i, output_1, valid, 16'h0C00 + 16'(i));
         end
      end
      checks++;
      if (empty !== 1'b1 || count !== 6'd0) begin
         failures++;
         $display("FAIL mid_drain empty=%b count=%0d want=1/0", empty, count);
      end
   endtask

   initial begin
      exp_out = 16'h0; exp_valid = 1'b0; exp_ovf = 0;
      test_reset();
      test_basic_order();
      test_fill_overflow();
      test_simultaneous();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/queue_write_module.md
Name: queue_write_module

Overview:
- Write-side endpoint of a KPN channel.
- Accepts tokens pushed by an upstream process using a wr strobe and data word, and buffers them in a circular register array.
- Delivers tokens to the downstream process through a registered rd/valid read port.
- Pairs with the existing precharged read-only queue and completes the channel, so a producer process can feed a consumer process.

Parameters:
- BITS_NUMBER, 16: token width in bits.
- FIFO_ELEMENTS, 5: address width; depth is 2**FIFO_ELEMENTS (32 entries).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr  input  1  write strobe from the producer; sampled on the rising edge of clk.
- input_1  input  BITS_NUMBER  token written when wr=1.
- rd  input  1  read request from the consumer.
- output_1  output  BITS_NUMBER  registered read data.
- valid  output  1  output_1 holds a token popped on the previous edge.
- full  output  1  all 2**FIFO_ELEMENTS entries are occupied.
- empty  output  1  no entries are occupied.
- count  output  FIFO_ELEMENTS+1  current occupancy, 0 to 2**FIFO_ELEMENTS.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - w_ptr=0, r_ptr=0, count=0.
  - empty=1, full=0, valid=0, output_1=0.
  - Array contents are not reset. Reset mid-operation discards all stored tokens immediately.
- Write acceptance: wr_ok = wr & (~full | rd_ok).
  - When wr_ok, array[w_ptr] <= input_1 and w_ptr increments, wrapping modulo 2**FIFO_ELEMENTS.
- Read acceptance: rd_ok = rd & ~empty.
  - When rd_ok, output_1 <= array[r_ptr], valid <= 1, and r_ptr increments with wrap.
  - Otherwise output_1 <= 0 and valid <= 0.
- Latency:
  - Write to readable: a token written at edge N can first be popped at edge N+1. There is no fall-through.
  - Read: data is on output_1 one cycle after the accepted rd.
- Occupancy:
  - count +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
  - full = (count == 2**FIFO_ELEMENTS); empty = (count == 0).
  - Flags are registered or derived from registered count. Either way they are valid in the cycle after the edge.
- Boundary cases:
  - Empty with wr and rd in the same cycle: the write is accepted, the read is rejected (valid=0), count becomes 1.
  - Full with wr and rd in the same cycle: both are accepted, count stays at 2**FIFO_ELEMENTS, pointers advance.
  - Full with wr only: the write is dropped, with no state change and no corruption of stored data.
  - Empty with rd only: no state change, valid=0, output_1=0.
  - Pointer wrap from 31 to 0 is seamless, and full/empty are distinguished by count, not by pointer equality.

Optional Feature:
- Macro: QUEUE_OVERFLOW_COUNT_EN.
- With the macro defined:
  - Extra output overflow_count [15:0], reset 0.
  - Increments by 1 on each cycle where wr=1 and wr_ok=0, i.e. a dropped write.
  - Saturates at 16'hFFFF.
- Without the macro: the port and logic are absent, and dropped writes are silent.

Decomposition:
- Shared package kpn_queue_pkg holds:
  - BITS_NUMBER and FIFO_ELEMENTS defaults.
  - Token typedef token_t (logic [BITS_NUMBER-1:0]).
  - Pointer typedef ptr_t.
  - Constant QUEUE_DEPTH = 2**FIFO_ELEMENTS.
  - Both this block and the precharged read queue import it.
- One natural sub-module, queue_ptr_unit:
  - Owns a wrapping pointer with an increment enable.
  - Instantiated twice, once for the write pointer and once for the read pointer.
- Storage array and count stay in the top module.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle, release it, hold wr=0 and rd=0 for 5 cycles. Required: empty=1, full=0, count=0, valid=0, output_1=16'h0000 throughout, with the reset taking effect without waiting for a clock edge.
- Basic order: write 16'h0001 through 16'h0004 on consecutive cycles, then rd=1 for 4 cycles. Required: output_1 = 1, 2, 3, 4 with valid=1, each one cycle after its rd. Afterwards count=0 and empty=1.
- Fill and overflow: write 33 tokens 16'h0100 to 16'h0120 with rd=0. Required: full=1 after the 32nd write, count=32, the 33rd token is dropped, and readout returns 16'h0100 to 16'h011F exactly. With QUEUE_OVERFLOW_COUNT_EN defined, overflow_count=1.
- Simultaneous at boundaries:
  - At empty, wr=1 (16'hAAAA) and rd=1 together: valid=0 and count=1. The next rd returns 16'hAAAA.
  - At full, wr=1 (16'hBBBB) and rd=1 together: count stays 32, and 16'hBBBB is the last token read out.
- Wrap-around: run 100 cycles with wr=1 and rd=1 alternating with random stalls, with data equal to an incrementing counter. Required: the read sequence is strictly incrementing with no gaps or duplicates, and count always matches a scoreboard across the pointer wrap from 31 to 0.
- Reset mid-operation: with count=10, pulse rst_n=0 between clock edges. Required: count=0, empty=1 and valid=0 immediately. Subsequent writes and reads start from pointer 0.
